// File: rtl/spi_dac_writer_if.sv
// Request/SPI bundle between the ramp controller, the DAC writer and the DAC.
// The ramp controller drives the request, and the writer drives the SPI pins and status flags.
interface spi_dac_writer_if;
   logic       spi_start;
   logic [7:0] voltage;
   logic       sclk;
   logic       mosi;
   logic       cs_n;
   logic       busy;
   logic       done;
   logic       overrun;

   modport master (
      output spi_start, voltage,
      input  sclk, mosi, cs_n, busy, done, overrun
   );

   modport slave (
      input  spi_start, voltage,
      output sclk, mosi, cs_n, busy, done, overrun
   );
endinterface

// File: rtl/spi_dac_writer.sv
// Serialises each captured 8-bit voltage code as one 16-bit SPI mode-0 frame
// {CTRL, code, 4'b0000} to the bias DAC, MSB first. A one-deep pending slot
// holds a request that arrives mid-frame. Overwriting that slot raises overrun.
module spi_dac_writer #(
   parameter int         CLK_DIV = 4,
   parameter logic [3:0] CTRL    = 4'h3
) (
   input logic             clk,
   input logic             reset,
   spi_dac_writer_if.slave bus
);

   localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    bit_q, bit_d;
   logic          sclk_q, sclk_d;
   logic [15:0]   shreg_q, shreg_d;
   logic          pend_vld_q, pend_vld_d;
   logic [7:0]    pend_data_q, pend_data_d;
   logic          busy_s;
   logic          done_s;
   logic          overrun_s;
   logic          last_div;

   function automatic logic [15:0] frame_word(input logic [7:0] code);
      return {CTRL, code, 4'b0000};
   endfunction

   // State and datapath registers; reset aborts any frame immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         sclk_q     <= 1'b0;
         pend_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         sclk_q     <= sclk_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   // Shift and pending data need no reset: mosi is gated by state and the
   // pending data is only consumed when its valid flag is set
   always_ff @(posedge clk) begin
      shreg_q     <= shreg_d;
      pend_data_q <= pend_data_d;
   end

   // Next-state logic: divider and bit sequencing, pending slot, and the frame hand-off
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      bit_d       = bit_q;
      sclk_d      = sclk_q;
      shreg_d     = shreg_q;
      pend_vld_d  = pend_vld_q;
      pend_data_d = pend_data_q;
      done_s      = 1'b0;
      overrun_s   = 1'b0;
      busy_s      = (state_q != IDLE);
      last_div    = (div_q == DIV_LAST);

      // A request during a frame goes to the slot; a second one replaces it
      if (busy_s && bus.spi_start) begin
         pend_vld_d  = 1'b1;
         pend_data_d = bus.voltage;
         overrun_s   = pend_vld_q;
      end

      case (state_q)
         IDLE: begin
            if (bus.spi_start) begin
               state_d = SHIFT;
               shreg_d = frame_word(bus.voltage);
               div_d   = '0;
               bit_d   = '0;
               sclk_d  = 1'b0;
            end
         end
         SHIFT: begin
            if (last_div) begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Falling edge: present the next bit for the next rising edge
                  sclk_d  = 1'b0;
                  shreg_d = {shreg_q[14:0], 1'b0};
                  bit_d   = bit_q + 4'd1;
                  if (bit_q == 4'd15) begin
                     state_d = HOLD;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         HOLD: begin
            if (last_div) begin
               done_s = 1'b1;
               div_d  = '0;
               // pend_vld_d already includes a request that arrives on this cycle
               if (pend_vld_d) begin
                  state_d    = SHIFT;
                  shreg_d    = frame_word(pend_data_d);
                  pend_vld_d = 1'b0;
                  bit_d      = '0;
                  sclk_d     = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.sclk    = sclk_q;
   assign bus.cs_n    = (state_q != SHIFT);
   assign bus.mosi    = (state_q == SHIFT) & shreg_q[15];
   assign bus.busy    = busy_s;
   assign bus.done    = done_s;
   assign bus.overrun = overrun_s;

endmodule

// File: tb/tb_spi_dac_writer.sv
// Directed bench for spi_dac_writer: a default instance (CLK_DIV=4) and a
// CLK_DIV=1 instance, each observed by a simple SPI slave model.
module tb_spi_dac_writer;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #10 clk = ~clk;

   spi_dac_writer_if bus ();
   spi_dac_writer_if bus1 ();

   spi_dac_writer #(.CLK_DIV(4), .CTRL(4'h3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   spi_dac_writer #(.CLK_DIV(1), .CTRL(4'h3)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   // SPI slave model: shift mosi in on sclk rise, log the word when cs_n rises
   logic [15:0] rx = '0, rx1 = '0;
   int          nbits = 0, nbits1 = 0;
   logic        p_sclk = 1'b0, p_cs = 1'b1, p_sclk1 = 1'b0, p_cs1 = 1'b1;
   logic [15:0] frames[$];
   int          fbits[$];
   logic [15:0] frames1[$];

   always @(bus.sclk or bus.cs_n) begin
      if (p_cs === 1'b1 && bus.cs_n === 1'b0) begin
         rx = '0; nbits = 0;
      end
      if (p_sclk !== 1'b1 && bus.sclk === 1'b1 && bus.cs_n === 1'b0) begin
         rx = {rx[14:0], bus.mosi}; nbits++;
      end
      if (p_cs === 1'b0 && bus.cs_n === 1'b1) begin
         frames.push_back(rx); fbits.push_back(nbits);
      end
      p_sclk = bus.sclk; p_cs = bus.cs_n;
   end

   always @(bus1.sclk or bus1.cs_n) begin
      if (p_cs1 === 1'b1 && bus1.cs_n === 1'b0) begin
         rx1 = '0; nbits1 = 0;
      end
      if (p_sclk1 !== 1'b1 && bus1.sclk === 1'b1 && bus1.cs_n === 1'b0) begin
         rx1 = {rx1[14:0], bus1.mosi}; nbits1++;
      end
      if (p_cs1 === 1'b0 && bus1.cs_n === 1'b1) frames1.push_back(rx1);
      p_sclk1 = bus1.sclk; p_cs1 = bus1.cs_n;
   end

   // Protocol watch, sampled once per cycle away from the active edge
   int   glitch = 0;
   int   idle_sclk = 0;
   logic prev_mosi = 1'b0;

   task automatic step(input logic st, input logic [7:0] v);
      @(negedge clk);
      bus.spi_start = st;
      bus.voltage   = v;
      #1;
      if (bus.sclk === 1'b1 && bus.cs_n === 1'b1) idle_sclk++;
      if (bus.sclk === 1'b1 && bus.mosi !== prev_mosi) glitch++;
      prev_mosi = bus.mosi;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.spi_start = 1'b0;  bus.voltage = 8'h00;
      bus1.spi_start = 1'b0; bus1.voltage = 8'h00;
      #1;
      total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", bus.cs_n); end
      total++; if (bus.sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", bus.sclk); end
      total++; if (bus.mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", bus.mosi); end
      total++; if ({bus.busy, bus.done, bus.overrun} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.done, bus.overrun}); end
      repeat (3) step(1'b0, 8'h00);
      @(negedge clk); reset = 1'b1;
      repeat (2) step(1'b0, 8'h00);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", bus.busy); end
   endtask

   task automatic test_single();
      int base, cs_low, first_low, done_at, ndone, busy_fall;
      logic [15:0] got;
      base = frames.size(); cs_low = 0; first_low = -1; done_at = -1; ndone = 0; busy_fall = -1;
      step(1'b1, 8'hA5);
      for (int i = 1; i <= 140; i++) begin
         step(1'b0, 8'h00);
         if (bus.cs_n === 1'b0) begin cs_low++; if (first_low < 0) first_low = i; end
         if (bus.done === 1'b1) begin ndone++; if (done_at < 0) done_at = i; end
         if (bus.busy !== 1'b1 && busy_fall < 0) busy_fall = i;
      end
      got = (frames.size() > base) ? frames[base] : 16'hxxxx;
      total++; if (got !== 16'h3A50) begin bad++; $display("FAIL single_frame got=%h want=3a50", got); end
      total++; if (first_low != 1) begin bad++; $display("FAIL single_cs_start got=%0d want=1", first_low); end
      total++; if (cs_low != 128) begin bad++; $display("FAIL single_cs_len got=%0d want=128", cs_low); end
      total++; if (done_at != 132 || ndone != 1) begin bad++; $display("FAIL single_done got=%0d/%0d want=132/1", done_at, ndone); end
      total++; if (busy_fall != 133) begin bad++; $display("FAIL single_busy_fall got=%0d want=133", busy_fall); end
   endtask

   task automatic test_codes();
      logic [7:0]  codes [2];
      logic [15:0] want  [2];
      logic [15:0] got;
      int          base, nb;
      codes[0] = 8'h00; want[0] = 16'h3000;
      codes[1] = 8'hFF; want[1] = 16'h3FF0;
      for (int k = 0; k < 2; k++) begin
         base = frames.size();
         step(1'b1, codes[k]);
         repeat (140) step(1'b0, 8'h00);
         got = (frames.size() > base) ? frames[base] : 16'hxxxx;
         nb  = (fbits.size() > base) ? fbits[base] : -1;
         total++; if (got !== want[k] || nb != 16) begin bad++; $display("FAIL code_frame_%0d got=%h/%0d bits want=%h/16", k, got, nb, want[k]); end
      end
      total++; if (glitch != 0) begin bad++; $display("FAIL mosi_stable got=%0d changes want=0", glitch); end
      total++; if (idle_sclk != 0 || bus.sclk !== 1'b0) begin bad++; $display("FAIL sclk_idle got=%0d/%b want=0/0", idle_sclk, bus.sclk); end
   endtask

   task automatic test_overrun();
      int base, novr, ndone, gaps, busy_fall;
      logic ovr20, ovr40, cs133;
      logic st;
      logic [7:0] v;
      base = frames.size(); novr = 0; ndone = 0; gaps = 0; busy_fall = -1;
      ovr20 = 1'bx; ovr40 = 1'bx; cs133 = 1'bx;
      step(1'b1, 8'hA5);
      for (int i = 1; i <= 300; i++) begin
         st = 1'b0; v = 8'h00;
         if (i == 20) begin st = 1'b1; v = 8'h12; end
         if (i == 40) begin st = 1'b1; v = 8'h34; end
         step(st, v);
         if (i == 20) ovr20 = bus.overrun;
         if (i == 40) ovr40 = bus.overrun;
         if (i == 133) cs133 = bus.cs_n;
         if (bus.overrun === 1'b1) novr++;
         if (bus.done === 1'b1) ndone++;
         if (i <= 264 && bus.busy !== 1'b1) gaps++;
         if (i > 264 && bus.busy !== 1'b1 && busy_fall < 0) busy_fall = i;
      end
      total++; if (ovr20 !== 1'b0 || ovr40 !== 1'b1 || novr != 1) begin bad++; $display("FAIL overrun_pulse got=%b/%b/%0d want=0/1/1", ovr20, ovr40, novr); end
      total++; if (frames.size() < base + 2 || frames[base] !== 16'h3A50 || frames[base+1] !== 16'h3340) begin bad++; $display("FAIL overrun_frames got=%0d frames want=3a50,3340", frames.size() - base); end
      total++; if (gaps != 0 || cs133 !== 1'b0) begin bad++; $display("FAIL b2b_no_idle got=%0d gaps cs133=%b want=0/0", gaps, cs133); end
      total++; if (busy_fall != 265 || ndone != 2) begin bad++; $display("FAIL b2b_end got=%0d/%0d want=265/2", busy_fall, ndone); end
   endtask

   task automatic test_done_queue();
      int base;
      logic d132, o132, cs133, b133;
      base = frames.size();
      d132 = 1'bx; o132 = 1'bx; cs133 = 1'bx; b133 = 1'bx;
      step(1'b1, 8'h11);
      for (int i = 1; i <= 280; i++) begin
         step(i == 132, 8'h22);
         if (i == 132) begin d132 = bus.done; o132 = bus.overrun; end
         if (i == 133) begin cs133 = bus.cs_n; b133 = bus.busy; end
      end
      total++; if (d132 !== 1'b1 || o132 !== 1'b0) begin bad++; $display("FAIL doneq_flags got=%b/%b want=1/0", d132, o132); end
      total++; if (cs133 !== 1'b0 || b133 !== 1'b1) begin bad++; $display("FAIL doneq_restart got=%b/%b want=0/1", cs133, b133); end
      total++; if (frames.size() < base + 2 || frames[base] !== 16'h3110 || frames[base+1] !== 16'h3220) begin bad++; $display("FAIL doneq_frames got=%0d frames want=3110,3220", frames.size() - base); end
   endtask

   task automatic test_reset_mid();
      int base, nb;
      logic [15:0] got;
      step(1'b1, 8'h77);
      for (int i = 1; i <= 61; i++) step(1'b0, 8'h00);
      total++; if (bus.sclk !== 1'b1 || bus.cs_n !== 1'b0) begin bad++; $display("FAIL midrst_pre got=%b/%b want=1/0", bus.sclk, bus.cs_n); end
      @(negedge clk); reset = 1'b0; #1;
      total++; if ({bus.cs_n, bus.sclk, bus.busy, bus.mosi} !== 4'b1000) begin bad++; $display("FAIL midrst_async got=%b want=1000", {bus.cs_n, bus.sclk, bus.busy, bus.mosi}); end
      repeat (3) step(1'b0, 8'h00);
      @(negedge clk); reset = 1'b1;
      repeat (3) step(1'b0, 8'h00);
      total++; if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin bad++; $display("FAIL midrst_no_resume got=%b/%b want=0/1", bus.busy, bus.cs_n); end
      base = frames.size();
      step(1'b1, 8'h5C);
      repeat (140) step(1'b0, 8'h00);
      got = (frames.size() > base) ? frames[base] : 16'hxxxx;
      nb  = (fbits.size() > base) ? fbits[base] : -1;
      total++; if (got !== 16'h35C0 || nb != 16) begin bad++; $display("FAIL midrst_frame got=%h/%0d want=35c0/16", got, nb); end
   endtask

   task automatic test_div1();
      int base, bcnt, novr;
      logic [15:0] want;
      base = frames1.size(); novr = 0;
      for (int k = 0; k < 5; k++) begin
         bcnt = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus1.spi_start = (i == 0);
            bus1.voltage   = 8'(k + 1);
            #1;
            if (bus1.busy === 1'b1) bcnt++;
            if (bus1.overrun === 1'b1) novr++;
         end
         want = {4'h3, 8'(k + 1), 4'h0};
         total++; if (bcnt != 33) begin bad++; $display("FAIL div1_busy_%0d got=%0d want=33", k, bcnt); end
         total++; if (frames1.size() <= base + k || frames1[base+k] !== want) begin bad++; $display("FAIL div1_frame_%0d got=%0d frames want=%h", k, frames1.size() - base, want); end
      end
      total++; if (novr != 0) begin bad++; $display("FAIL div1_overrun got=%0d want=0", novr); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_codes();
      test_overrun();
      test_done_queue();
      test_reset_mid();
      test_div1();
      total++; if (glitch != 0 || idle_sclk != 0) begin bad++; $display("FAIL protocol_final got=%0d/%0d want=0/0", glitch, idle_sclk); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
